// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and the general-call address.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX_DATA,
    ST_RX_ACK,
    ST_TX_DATA,
    ST_TX_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic [6:0] GENERAL_CALL_ADDR = 7'h00;

  // General call only answers when the target itself sits at address 0.
  function automatic logic addr_match(input logic [6:0] rx_addr, input logic [6:0] own_addr);
    return (rx_addr == own_addr) &&
           ((rx_addr != GENERAL_CALL_ADDR) || (own_addr == GENERAL_CALL_ADDR));
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer plus history flop for one I2C pad line; flags rise and fall.
module i2c_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  // sync_q[0] meta, sync_q[1] synchronized level, sync_q[2] previous level
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 3'b111;
    else          sync_q <= {sync_q[1:0], pin};
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/i2c_target.sv
// I2C target (7-bit address, no clock stretching); SDA is open-drain via sda_oe.
//
// state        | meaning
// ST_IDLE      | bus free or not yet seen a START
// ST_ADDR      | shifting in address + R/W
// ST_ADDR_ACK  | driving ACK for our address
// ST_RX_DATA   | shifting in a write byte
// ST_RX_ACK    | driving ACK for a received byte
// ST_TX_DATA   | shifting out a read byte
// ST_TX_ACK    | sampling initiator ACK/NACK
// ST_WAIT_STOP | not addressed or NACKed; idle until START/STOP
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] data_in,
  output logic       data_req,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       busy
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;
  logic start, stop;

  i2c_state_e state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       byte_done;
  logic       load_pending;
  logic       rw;

  i2c_sync_edge u_scl (.clk(clk), .reset_n(reset_n), .pin(scl_in),
                       .level(scl), .rise(scl_rise), .fall(scl_fall));
  i2c_sync_edge u_sda (.clk(clk), .reset_n(reset_n), .pin(sda_in),
                       .level(sda), .rise(sda_rise), .fall(sda_fall));

  assign start = sda_fall & scl;
  assign stop  = sda_rise & scl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= 3'd7;
      shift_reg    <= 8'h00;
      byte_done    <= 1'b0;
      load_pending <= 1'b0;
      rw           <= 1'b0;
      sda_oe       <= 1'b0;
      data_req     <= 1'b0;
      data_ready   <= 1'b0;
      data_out     <= 8'h00;
      busy         <= 1'b0;
    end else begin
      data_req     <= 1'b0;
      data_ready   <= 1'b0;
      load_pending <= 1'b0;
      if (load_pending) shift_reg <= data_in;

      case (state)
        ST_ADDR, ST_RX_DATA: begin
          if (scl_rise) begin
            shift_reg <= {shift_reg[6:0], sda};
            bit_cnt   <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) byte_done <= 1'b1;
          end else if (scl_fall && byte_done) begin
            byte_done <= 1'b0;
            if (state == ST_RX_DATA) begin
              data_out   <= shift_reg;
              data_ready <= 1'b1;
              sda_oe     <= 1'b1;
              state      <= ST_RX_ACK;
            end else if (addr_match(shift_reg[7:1], TARGET_ADDR)) begin
              state  <= ST_ADDR_ACK;
              sda_oe <= 1'b1;
              busy   <= 1'b1;
              rw     <= shift_reg[0];
              if (shift_reg[0]) begin
                data_req     <= 1'b1;
                load_pending <= 1'b1;
              end
            end else begin
              state  <= ST_WAIT_STOP;
              sda_oe <= 1'b0;
              busy   <= 1'b0;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            state  <= rw ? ST_TX_DATA : ST_RX_DATA;
            sda_oe <= rw ? ~shift_reg[7] : 1'b0;
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            sda_oe <= 1'b0;
            state  <= ST_RX_DATA;
          end
        end
        ST_TX_DATA: begin
          // Bit 7 is already on the bus at entry; each fall advances one bit.
          if (scl_fall) begin
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              sda_oe <= 1'b0;
              state  <= ST_TX_ACK;
            end else begin
              sda_oe    <= ~shift_reg[6];
              shift_reg <= {shift_reg[6:0], 1'b0};
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (sda) begin
              state <= ST_WAIT_STOP;
            end else begin
              data_req     <= 1'b1;
              load_pending <= 1'b1;
            end
          end else if (scl_fall) begin
            state  <= ST_TX_DATA;
            sda_oe <= ~shift_reg[7];
          end
        end
        default: ;
      endcase

      // Bus conditions override whatever the byte engine decided this clk.
      if (start) begin
        state     <= ST_ADDR;
        bit_cnt   <= 3'd7;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (stop) begin
        state     <= ST_IDLE;
        bit_cnt   <= 3'd7;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bit-banged I2C initiator driving i2c_target, checked against a transaction-level model.
module tb_i2c_target;

  localparam logic [6:0] OWN = 7'h42;
  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       sda_oe, data_req, data_ready, busy;
  logic [7:0] data_out;
  logic       sda_line;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target #(.TARGET_ADDR(OWN)) dut (
    .clk(clk), .reset_n(reset_n), .scl_in(scl_m), .sda_in(sda_line),
    .sda_oe(sda_oe), .data_in(data_in), .data_req(data_req),
    .data_out(data_out), .data_ready(data_ready), .busy(busy)
  );

  int n_vec = 0, n_err = 0;
  int rdy_cnt = 0, req_cnt = 0, oe_cnt = 0;
  logic [7:0] exp_out = 8'h00;
  logic [7:0] tx_b [4];

  always @(negedge clk) begin
    if (data_ready) rdy_cnt++;
    if (data_req)   req_cnt++;
    if (sda_oe)     oe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_match(input logic [6:0] a);
    return (a == OWN) && (a != 7'h00 || OWN == 7'h00);
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    b = sda_line; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic put_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(ack);
  endtask

  task automatic write_txn(input logic [6:0] addr, input int n, input logic do_stop);
    logic ack, m;
    int rdy0, oe0;
    m = model_match(addr);
    rdy0 = rdy_cnt;
    oe0 = oe_cnt;
    bus_start();
    put_byte({addr, 1'b0}, ack);
    chk("wr_addr_ack", ack, m ? 0 : 1);
    for (int i = 0; i < n; i++) begin
      put_byte(tx_b[i], ack);
      chk("wr_data_ack", ack, m ? 0 : 1);
      if (m) exp_out = tx_b[i];
      chk("wr_data_out", data_out, exp_out);
    end
    chk("wr_ready_cnt", rdy_cnt - rdy0, m ? n : 0);
    chk("wr_busy", busy, m);
    if (!m) chk("wr_oe_never", oe_cnt - oe0, 0);
    if (do_stop) begin
      bus_stop(); wait_clk(2);
      chk("wr_busy_stop", busy, 0);
    end
  endtask

  task automatic read_txn(input logic [6:0] addr, input int n);
    logic ack, b, m;
    logic [7:0] got;
    int req0;
    m = model_match(addr);
    req0 = req_cnt;
    data_in = tx_b[0];
    bus_start();
    put_byte({addr, 1'b1}, ack);
    chk("rd_addr_ack", ack, m ? 0 : 1);
    chk("rd_busy", busy, m);
    for (int i = 0; i < n; i++) begin
      for (int k = 7; k >= 0; k--) begin
        get_bit(b);
        got[k] = b;
      end
      chk("rd_data", got, m ? tx_b[i] : 8'hFF);
      if (i + 1 < n) data_in = tx_b[i + 1];
      put_bit(i + 1 == n);
    end
    wait_clk(2);
    chk("rd_oe_after_nack", sda_oe, 0);
    chk("rd_req_cnt", req_cnt - req0, m ? n : 0);
    bus_stop(); wait_clk(2);
    chk("rd_busy_stop", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack, b;
    logic [6:0] a;
    int         n, rdy0;

    wait_clk(3);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_data_req", data_req, 0);
    chk("rst_data_ready", data_ready, 0);
    reset_n = 1'b1;
    wait_clk(Q);

    // write A5 to our address
    tx_b[0] = 8'hA5;
    write_txn(OWN, 1, 1'b1);

    // read 3C then C3, ACK then NACK
    tx_b[0] = 8'h3C; tx_b[1] = 8'hC3;
    read_txn(OWN, 2);

    // neighbour address and general call are ignored
    tx_b[0] = 8'h99;
    write_txn(7'h43, 1, 1'b1);
    tx_b[0] = 8'h77;
    write_txn(7'h00, 1, 1'b1);

    // write 11, repeated START, read back
    tx_b[0] = 8'h11;
    write_txn(OWN, 1, 1'b0);
    tx_b[0] = 8'h96;
    read_txn(OWN, 1);

    // reset during bit 4 of a read byte
    tx_b[0] = 8'h00; data_in = 8'h00;
    bus_start();
    put_byte({OWN, 1'b1}, ack);
    chk("rr_addr_ack", ack, 0);
    for (int k = 0; k < 3; k++) get_bit(b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(1);
    chk("rr_oe_before", sda_oe, 1);
    reset_n = 1'b0;
    #1;
    chk("rr_oe_reset", sda_oe, 0);
    chk("rr_busy_reset", busy, 0);
    exp_out = 8'h00;
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(Q);
    chk("rr_data_out", data_out, exp_out);
    tx_b[0] = 8'h5A;
    write_txn(OWN, 1, 1'b1);

    // STOP in the middle of a received byte
    bus_start();
    put_byte({OWN, 1'b0}, ack);
    chk("ms_addr_ack", ack, 0);
    rdy0 = rdy_cnt;
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
    bus_stop(); wait_clk(2);
    chk("ms_ready_cnt", rdy_cnt - rdy0, 0);
    chk("ms_sda_oe", sda_oe, 0);
    chk("ms_busy", busy, 0);
    chk("ms_data_out", data_out, exp_out);

    // randomized transactions
    for (int t = 0; t < 8; t++) begin
      a = ($urandom_range(0, 2) == 0) ? 7'($urandom) : OWN;
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) tx_b[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) read_txn(a, n);
      else write_txn(a, n, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 The block SHALL have parameter TARGET_ADDR, default 7'h42, meaning the 7-bit address this target answers to.
REQ-002 The block SHALL have port clk  input  1  system clock, rising-edge only; frequency at least 8x the SCL rate.
REQ-003 The block SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port scl_in  input  1  raw SCL from pad, asynchronous.
REQ-005 The block SHALL have port sda_in  input  1  raw SDA from pad, asynchronous.
REQ-006 The block SHALL have port sda_oe  output  1  1 = pull SDA low; 0 = release SDA (open-drain, pad drives 0 only).
REQ-007 The block SHALL have port data_in  input  8  byte returned to the initiator on a read; MSB is sent first.
REQ-008 The block SHALL have port data_req  output  1  one-clk pulse requesting the next data_in byte.
REQ-009 The block SHALL have port data_out  output  8  last byte received on a write; MSB is received first.
REQ-010 The block SHALL have port data_ready  output  1  one-clk pulse; data_out is valid.
REQ-011 The block SHALL have port busy  output  1  high from START until STOP when the target is addressed.

Function
REQ-012 scl_in and sda_in SHALL each pass through a 2-flop synchronizer plus one history flop; all edge and condition detection SHALL use the synchronized values.
REQ-013 START: synchronized SDA falls while SCL is high. STOP: synchronized SDA rises while SCL is high. Both SHALL be detected in any state, including repeated START.
REQ-014 States: IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP.
REQ-015 A START in any state SHALL go to ADDR with bit counter = 7 and sda_oe = 0.
REQ-016 A STOP in any state SHALL go to IDLE with sda_oe = 0 and busy = 0.
REQ-017 Data bits SHALL be sampled on the SCL rising edge.
REQ-018 sda_oe SHALL change only on the clk after an SCL falling edge, except for the START/STOP release.
REQ-019 ADDR SHALL shift in 7 address bits plus the R/W bit, MSB first. A 3-bit counter SHALL wrap from 0 to 7 between bytes.
REQ-020 Address match: after the 8th bit, at the next SCL fall, the block SHALL go to ADDR_ACK, set sda_oe = 1 and set busy = 1.
REQ-021 Address mismatch: the block SHALL go to WAIT_STOP, keep sda_oe = 0 and keep busy = 0.
REQ-022 The general-call address 7'h00 SHALL be treated as a mismatch unless TARGET_ADDR = 0.
REQ-023 ADDR_ACK with R/W = 0: at the SCL fall that ends the ACK, sda_oe = 0 and the block SHALL go to RX_DATA.
REQ-024 ADDR_ACK with R/W = 1: data_req SHALL pulse on entry to ADDR_ACK. data_in SHALL be latched into the shift register on the next clk. At the SCL fall that ends the ACK, the block SHALL go to TX_DATA and drive bit 7.
REQ-025 RX_DATA: after 8 bits, at the SCL fall, the block SHALL load data_out, pulse data_ready for 1 clk, set sda_oe = 1 and go to RX_ACK. The next SCL fall SHALL release SDA and return to RX_DATA.
REQ-026 TX_DATA: sda_oe = ~bit, updated after each SCL fall. After 8 bits the block SHALL release SDA and go to TX_ACK.
REQ-027 TX_ACK: the initiator's ACK/NACK SHALL be sampled on SCL rise.
  - ACK (0): pulse data_req, latch data_in on the next clk, return to TX_DATA at the SCL fall.
  - NACK (1): go to WAIT_STOP with SDA released.
REQ-028 WAIT_STOP SHALL ignore SCL activity until START or STOP.
REQ-029 If data_ready and a START/STOP occur in the same clk, data_ready SHALL still pulse and the START/STOP transition SHALL win.
REQ-030 Clock stretching is not supported; the block SHALL never drive SCL.

Reset
REQ-031 While reset_n = 0: state = IDLE, sda_oe = 0, data_req = 0, data_ready = 0, busy = 0, data_out = 8'h00, shift register = 0, counter = 7, synchronizer flops = 1.
REQ-032 Deassertion of reset_n mid-transfer SHALL leave the block in IDLE; it SHALL resume only at the next START.

Structure
REQ-033 State encodings and the general-call constant SHALL live in the shared package i2c_pkg, so that i2c_master and i2c_target use one definition.
REQ-034 The synchronizer and edge detector SHALL be one sub-module, i2c_sync_edge, instantiated once for SCL and once for SDA. It SHALL output the level, rise and fall.
REQ-035 The pad tristate SHALL stay outside i2c_target; the top level SHALL connect sda_oe to the pad's output enable with data tied to 0.

Verification
REQ-036 The bench SHALL cover: write to 7'h42, byte 8'hA5, then STOP -> ACK on address and on data, data_out = 8'hA5, one data_ready pulse, busy falls at STOP.
REQ-037 The bench SHALL cover: read from 7'h42 with data_in = 8'h3C then 8'hC3, initiator ACK then NACK -> SDA bits 00111100 then 11000011, two data_req pulses, SDA released after the NACK.
REQ-038 The bench SHALL cover: address 7'h43 write -> SDA never driven, data_ready never pulses, busy = 0.
REQ-039 The bench SHALL cover: write 8'h11, repeated START, read 7'h42 -> second transaction ACKed and data_req pulses, with no STOP in between.
REQ-040 The bench SHALL cover: reset_n asserted during bit 4 of a read byte -> sda_oe = 0 within the same clk; a following write 8'h5A completes normally.
REQ-041 The bench SHALL cover: STOP injected mid-byte during RX_DATA -> IDLE, no data_ready pulse, sda_oe = 0.
